// File: rtl/ahbl_regs_system_csr.sv
// AHB-Lite system configuration register bank feeding the system pass-through stage.
// Muxsplit switch groups use break-before-make so their analog switches never overlap.
//
// Bus data-phase FSM
//   state    | meaning
//   BUS_IDLE | no data phase in progress
//   BUS_DATA | OKAY data phase (zero wait state)
//   BUS_ERR1 | first ERROR cycle: hreadyout = 0, hresp = 1
//   BUS_ERR2 | second ERROR cycle: hreadyout = 1, hresp = 1
//
// Per-group BBM FSM
//   state    | meaning
//   BBM_IDLE | group output equals its target
//   BBM_GAP  | group output held at 0 while the counter runs down
module ahbl_regs_system_csr #(
  parameter int BBM_CYCLES = 4,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic [5:0]        bus_muxsplit_se,
  output logic [5:0]        bus_muxsplit_sw,
  output logic [5:0]        bus_muxsplit_ne,
  output logic [5:0]        bus_muxsplit_nw,
  output logic              bus_vref_e_vrefgen_en,
  output logic              bus_vref_w_vrefgen_en,
  output logic [4:0]        bus_vref_e_ref_sel,
  output logic [4:0]        bus_vref_w_ref_sel,
  output logic              bus_user_ahb_enable,
  output logic [15:0]       bus_user_irqs_enable,
  output logic [5:0]        bus_sio_cfg,
  input  logic              bus_mgmt_select
);

  typedef enum logic [1:0] {BUS_IDLE, BUS_DATA, BUS_ERR1, BUS_ERR2} bus_state_e;
  typedef enum logic {BBM_IDLE, BBM_GAP} bbm_state_e;

  localparam logic [3:0] BBM_LOAD = 4'(BBM_CYCLES);

  bus_state_e bus_state_q, bus_state_d;
  logic [2:0] addr_q, addr_d;
  logic       write_q, write_d;

  bbm_state_e bbm_state_q [4];
  bbm_state_e bbm_state_d [4];
  logic [3:0] cnt_q [4];
  logic [3:0] cnt_d [4];
  logic [5:0] tgt_q [4];
  logic [5:0] tgt_d [4];
  logic [5:0] out_q [4];
  logic [5:0] out_d [4];
  logic [3:0] busy;

  logic       e_en_q, e_en_d, w_en_q, w_en_d;
  logic [4:0] e_sel_q, e_sel_d, w_sel_q, w_sel_d;
  logic       ahb_en_q, ahb_en_d;
  logic [15:0] irqs_q, irqs_d;
  logic [5:0] sio_q, sio_d;
  logic       mgmt_meta_q, mgmt_meta_d, mgmt_sync_q, mgmt_sync_d;

  logic        accept, addr_err, wr_en, rd_en;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign accept   = hsel & hready & htrans[1];
  assign addr_err = (hsize != 3'b010) | haddr[5];
  assign wr_en    = (bus_state_q == BUS_DATA) & write_q;
  assign rd_en    = (bus_state_q == BUS_DATA) & ~write_q;
  // Only word offsets 0x00..0x1C are decoded; remaining bits are don't-care.
  assign unused_bits = ^{haddr, hwdata[15:14]};

  always_comb begin
    bus_state_d = BUS_IDLE;
    addr_d      = addr_q;
    write_d     = write_q;
    if (bus_state_q == BUS_ERR1) begin
      bus_state_d = BUS_ERR2;
    end else if (accept) begin
      addr_d      = haddr[4:2];
      write_d     = hwrite;
      bus_state_d = addr_err ? BUS_ERR1 : BUS_DATA;
    end
  end

  assign hreadyout = (bus_state_q != BUS_ERR1);
  assign hresp     = (bus_state_q == BUS_ERR1) | (bus_state_q == BUS_ERR2);

  always_comb begin
    e_en_d   = e_en_q;
    e_sel_d  = e_sel_q;
    w_en_d   = w_en_q;
    w_sel_d  = w_sel_q;
    ahb_en_d = ahb_en_q;
    irqs_d   = irqs_q;
    sio_d    = sio_q;
    if (wr_en) begin
      case (addr_q)
        3'd4: begin
          e_en_d  = hwdata[0];
          e_sel_d = hwdata[5:1];
          w_en_d  = hwdata[8];
          w_sel_d = hwdata[13:9];
        end
        3'd5: begin
          ahb_en_d = hwdata[0];
          irqs_d   = hwdata[31:16];
        end
        3'd6: sio_d = hwdata[5:0];
        default: ;
      endcase
    end
  end

  // A write during a gap restarts the gap so the new target also gets a full break.
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      bbm_state_d[g] = bbm_state_q[g];
      cnt_d[g]       = cnt_q[g];
      tgt_d[g]       = tgt_q[g];
      out_d[g]       = out_q[g];
      case (bbm_state_q[g])
        BBM_IDLE: begin
          if (wr_en && addr_q == 3'(g)) begin
            tgt_d[g] = hwdata[5:0];
            if (hwdata[5:0] != out_q[g]) begin
              out_d[g]       = '0;
              cnt_d[g]       = BBM_LOAD;
              bbm_state_d[g] = BBM_GAP;
            end
          end
        end
        default: begin
          if (wr_en && addr_q == 3'(g)) begin
            tgt_d[g] = hwdata[5:0];
            cnt_d[g] = BBM_LOAD;
          end else if (cnt_q[g] == 4'd1) begin
            cnt_d[g]       = '0;
            out_d[g]       = tgt_q[g];
            bbm_state_d[g] = BBM_IDLE;
          end else begin
            cnt_d[g] = cnt_q[g] - 4'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      busy[g] = (bbm_state_q[g] == BBM_GAP);
    end
  end

  assign mgmt_meta_d = bus_mgmt_select;
  assign mgmt_sync_d = mgmt_meta_q;

  always_comb begin
    rd_data = '0;
    case (addr_q)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = {26'b0, tgt_q[addr_q[1:0]]};
      3'd4: rd_data = {18'b0, w_sel_q, w_en_q, 2'b0, e_sel_q, e_en_q};
      3'd5: rd_data = {irqs_q, 15'b0, ahb_en_q};
      3'd6: rd_data = {26'b0, sio_q};
      default: rd_data = {24'b0, busy, 3'b0, mgmt_sync_q};
    endcase
  end

  assign hrdata = rd_en ? rd_data : 32'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state_q <= BUS_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      e_en_q      <= 1'b0;
      e_sel_q     <= '0;
      w_en_q      <= 1'b0;
      w_sel_q     <= '0;
      ahb_en_q    <= 1'b0;
      irqs_q      <= '0;
      sio_q       <= '0;
      mgmt_meta_q <= 1'b0;
      mgmt_sync_q <= 1'b0;
      for (int g = 0; g < 4; g++) begin
        bbm_state_q[g] <= BBM_IDLE;
        cnt_q[g]       <= '0;
        tgt_q[g]       <= '0;
        out_q[g]       <= '0;
      end
    end else begin
      bus_state_q <= bus_state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      e_en_q      <= e_en_d;
      e_sel_q     <= e_sel_d;
      w_en_q      <= w_en_d;
      w_sel_q     <= w_sel_d;
      ahb_en_q    <= ahb_en_d;
      irqs_q      <= irqs_d;
      sio_q       <= sio_d;
      mgmt_meta_q <= mgmt_meta_d;
      mgmt_sync_q <= mgmt_sync_d;
      for (int g = 0; g < 4; g++) begin
        bbm_state_q[g] <= bbm_state_d[g];
        cnt_q[g]       <= cnt_d[g];
        tgt_q[g]       <= tgt_d[g];
        out_q[g]       <= out_d[g];
      end
    end
  end

  assign bus_muxsplit_se       = out_q[0];
  assign bus_muxsplit_sw       = out_q[1];
  assign bus_muxsplit_ne       = out_q[2];
  assign bus_muxsplit_nw       = out_q[3];
  assign bus_vref_e_vrefgen_en = e_en_q;
  assign bus_vref_e_ref_sel    = e_sel_q;
  assign bus_vref_w_vrefgen_en = w_en_q;
  assign bus_vref_w_ref_sel    = w_sel_q;
  assign bus_user_ahb_enable   = ahb_en_q;
  assign bus_user_irqs_enable  = irqs_q;
  assign bus_sio_cfg           = sio_q;

endmodule

// File: tb/tb_ahbl_regs_system_csr.sv
// Directed bench for ahbl_regs_system_csr: reset, BBM gaps, config writes, errors, mgmt sync.
module tb_ahbl_regs_system_csr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic [5:0]  haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic [5:0]  se, sw, ne, nw;
  logic        e_en, w_en;
  logic [4:0]  e_sel, w_sel;
  logic        ahb_en;
  logic [15:0] irqs;
  logic [5:0]  sio;
  logic        mgmt = 1'b0;

  int errors = 0;
  int checks = 0;

  assign hready = hreadyout;

  always #5 clk = ~clk;

  ahbl_regs_system_csr #(.BBM_CYCLES(4), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .bus_muxsplit_se(se), .bus_muxsplit_sw(sw), .bus_muxsplit_ne(ne), .bus_muxsplit_nw(nw),
    .bus_vref_e_vrefgen_en(e_en), .bus_vref_w_vrefgen_en(w_en),
    .bus_vref_e_ref_sel(e_sel), .bus_vref_w_ref_sel(w_sel),
    .bus_user_ahb_enable(ahb_en), .bus_user_irqs_enable(irqs),
    .bus_sio_cfg(sio), .bus_mgmt_select(mgmt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [5:0] a, input logic w, input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
  endtask

  task automatic bus_idle;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d);
    set_addr(a, 1'b1, 3'b010);
    tick;
    bus_idle;
    hwdata = d;
    tick;
  endtask

  task automatic test_reset;
    logic [67:0] outs;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    outs = {se, sw, ne, nw, e_en, w_en, e_sel, w_sel, ahb_en, irqs, sio};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    for (int i = 0; i < 8; i++) begin
      set_addr(6'(i * 4), 1'b0, 3'b010);
      tick;
      bus_idle;
      checks++;
      if (hrdata !== 32'h0 || hreadyout !== 1'b1 || hresp !== 1'b0) begin
        errors++;
        $display("FAIL reset_read[%0d]: got rdata=%h rdy=%b resp=%b expected 0/1/0", i, hrdata, hreadyout, hresp);
      end
      tick;
    end
  endtask

  task automatic test_bbm_se;
    do_write(6'h00, 32'h15);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (se !== 6'h00) begin
        errors++; $display("FAIL se_gap[%0d]: got %h expected 00", i, se);
      end
      tick;
    end
    checks++;
    if (se !== 6'h15) begin
      errors++; $display("FAIL se_after_gap: got %h expected 15", se);
    end
    do_write(6'h00, 32'h15);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (se !== 6'h15) begin
        errors++; $display("FAIL se_same_value[%0d]: got %h expected 15", i, se);
      end
      tick;
    end
    do_write(6'h00, 32'h2A);
    set_addr(6'h1C, 1'b0, 3'b010);
    tick;
    bus_idle;
    checks++;
    if (hrdata !== 32'h10) begin
      errors++; $display("FAIL status_busy_se: got %h expected 00000010", hrdata);
    end
    tick; tick; tick;
    checks++;
    if (se !== 6'h2A) begin
      errors++; $display("FAIL se_second_value: got %h expected 2a", se);
    end
    set_addr(6'h1C, 1'b0, 3'b010);
    tick;
    bus_idle;
    checks++;
    if (hrdata !== 32'h0) begin
      errors++; $display("FAIL status_idle_se: got %h expected 00000000", hrdata);
    end
    tick;
  endtask

  task automatic test_ne_reload;
    do_write(6'h08, 32'h3F);
    tick; tick;
    do_write(6'h08, 32'h01);
    checks++;
    if (ne !== 6'h00) begin
      errors++; $display("FAIL ne_reload_start: got %h expected 00", ne);
    end
    set_addr(6'h08, 1'b0, 3'b010);
    tick;
    bus_idle;
    checks++;
    if (hrdata !== 32'h01) begin
      errors++; $display("FAIL ne_readback_gap: got %h expected 00000001", hrdata);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ne !== 6'h00) begin
        errors++; $display("FAIL ne_gap[%0d]: got %h expected 00", i, ne);
      end
      tick;
    end
    checks++;
    if (ne !== 6'h01) begin
      errors++; $display("FAIL ne_after_gap: got %h expected 01", ne);
    end
  endtask

  task automatic test_back_to_back;
    set_addr(6'h10, 1'b1, 3'b010);
    tick;
    hwdata = 32'h0000_3F3F;
    set_addr(6'h14, 1'b1, 3'b010);
    tick;
    checks++;
    if ({w_sel, w_en, e_sel, e_en} !== {5'h1F, 1'b1, 5'h1F, 1'b1}) begin
      errors++; $display("FAIL vref_outputs: got %h expected %h", {w_sel, w_en, e_sel, e_en}, {5'h1F, 1'b1, 5'h1F, 1'b1});
    end
    hwdata = 32'hA5A5_0001;
    set_addr(6'h18, 1'b1, 3'b010);
    tick;
    checks++;
    if ({irqs, ahb_en} !== {16'hA5A5, 1'b1}) begin
      errors++; $display("FAIL user_outputs: got %h expected %h", {irqs, ahb_en}, {16'hA5A5, 1'b1});
    end
    hwdata = 32'h0000_002A;
    set_addr(6'h18, 1'b0, 3'b010);
    tick;
    checks++;
    if (sio !== 6'h2A) begin
      errors++; $display("FAIL sio_output: got %h expected 2a", sio);
    end
    checks++;
    if (hrdata !== 32'h2A) begin
      errors++; $display("FAIL sio_read_after_write: got %h expected 0000002a", hrdata);
    end
    set_addr(6'h10, 1'b0, 3'b010);
    tick;
    checks++;
    if (hrdata !== 32'h0000_3F3F) begin
      errors++; $display("FAIL vref_readback: got %h expected 00003f3f", hrdata);
    end
    set_addr(6'h14, 1'b0, 3'b010);
    tick;
    checks++;
    if (hrdata !== 32'hA5A5_0001) begin
      errors++; $display("FAIL user_readback: got %h expected a5a50001", hrdata);
    end
    bus_idle;
    tick;
  endtask

  task automatic test_error;
    set_addr(6'h00, 1'b1, 3'b000);
    tick;
    bus_idle;
    hwdata = 32'h3F;
    checks++;
    if (hreadyout !== 1'b0 || hresp !== 1'b1) begin
      errors++; $display("FAIL byte_err_cycle1: got rdy=%b resp=%b expected 0/1", hreadyout, hresp);
    end
    tick;
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 1'b1) begin
      errors++; $display("FAIL byte_err_cycle2: got rdy=%b resp=%b expected 1/1", hreadyout, hresp);
    end
    tick;
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0 || se !== 6'h2A) begin
      errors++; $display("FAIL byte_err_after: got rdy=%b resp=%b se=%h expected 1/0/2a", hreadyout, hresp, se);
    end
    set_addr(6'h00, 1'b0, 3'b010);
    tick;
    bus_idle;
    checks++;
    if (hrdata !== 32'h2A) begin
      errors++; $display("FAIL se_unchanged_read: got %h expected 0000002a", hrdata);
    end
    tick;
    set_addr(6'h20, 1'b0, 3'b010);
    tick;
    bus_idle;
    checks++;
    if (hreadyout !== 1'b0 || hresp !== 1'b1) begin
      errors++; $display("FAIL range_err_cycle1: got rdy=%b resp=%b expected 0/1", hreadyout, hresp);
    end
    tick;
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 1'b1) begin
      errors++; $display("FAIL range_err_cycle2: got rdy=%b resp=%b expected 1/1", hreadyout, hresp);
    end
    tick;
  endtask

  task automatic test_parallel_gaps;
    set_addr(6'h04, 1'b1, 3'b010);
    tick;
    hwdata = 32'h01;
    set_addr(6'h0C, 1'b1, 3'b010);
    tick;
    hwdata = 32'h02;
    bus_idle;
    tick; tick; tick; tick;
    checks++;
    if (sw !== 6'h01 || nw !== 6'h00) begin
      errors++; $display("FAIL parallel_gap_a: got sw=%h nw=%h expected 01/00", sw, nw);
    end
    tick;
    checks++;
    if (sw !== 6'h01 || nw !== 6'h02) begin
      errors++; $display("FAIL parallel_gap_b: got sw=%h nw=%h expected 01/02", sw, nw);
    end
  endtask

  task automatic test_mgmt_sync;
    mgmt = 1'b1;
    set_addr(6'h1C, 1'b0, 3'b010);
    tick;
    checks++;
    if (hrdata !== 32'h0) begin
      errors++; $display("FAIL mgmt_one_cycle: got %h expected 00000000", hrdata);
    end
    tick;
    bus_idle;
    checks++;
    if (hrdata !== 32'h1) begin
      errors++; $display("FAIL mgmt_two_cycles: got %h expected 00000001", hrdata);
    end
    mgmt = 1'b0;
    tick; tick; tick;
    set_addr(6'h1C, 1'b0, 3'b010);
    tick;
    bus_idle;
    checks++;
    if (hrdata !== 32'h0) begin
      errors++; $display("FAIL mgmt_cleared: got %h expected 00000000", hrdata);
    end
    tick;
  endtask

  task automatic test_reset_mid_gap;
    logic [67:0] outs;
    do_write(6'h04, 32'h3F);
    tick;
    rst_n = 1'b0;
    #1;
    outs = {se, sw, ne, nw, e_en, w_en, e_sel, w_sel, ahb_en, irqs, sio};
    checks++;
    if (outs !== '0 || hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
      errors++; $display("FAIL async_reset: got outs=%h rdy=%b resp=%b rdata=%h expected 0/1/0/0", outs, hreadyout, hresp, hrdata);
    end
    tick;
    rst_n = 1'b1;
    repeat (6) tick;
    checks++;
    if (sw !== 6'h00) begin
      errors++; $display("FAIL gap_aborted: got sw=%h expected 00", sw);
    end
    set_addr(6'h04, 1'b0, 3'b010);
    tick;
    bus_idle;
    checks++;
    if (hrdata !== 32'h0) begin
      errors++; $display("FAIL sw_target_reset: got %h expected 00000000", hrdata);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_bbm_se;
    test_ne_reload;
    test_back_to_back;
    test_error;
    test_parallel_gaps;
    test_mgmt_sync;
    test_reset_mid_gap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
